ddr3_port_arbiter: RTL

//   Shares one MIG DDR3 user interface (app_*) between two requester ports, e.g. sensor write path and host read path.

---
 rtl/ddr3_arb_pkg.sv | 6 +
 rtl/ddr3_arb_tag_fifo.sv | 38 +++
 rtl/ddr3_port_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared FSM states and MIG command encodings for the DDR3 port arbiter
package ddr3_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, WR, RD} state_t;
  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;
endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// ddr3_arb_tag_fifo: 1-bit port tag FIFO routing in-order read returns back to the issuing port
module ddr3_arb_tag_fifo #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  logic mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push_ok, pop_ok;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign dout    = mem[rp];
  // tag storage, no reset needed since the count gates every read
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
  // pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk)
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: round-robin two-port arbiter onto one MIG DDR3 app interface (optional DDR3_ARB_STATS_EN burst counters)
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 256,
  parameter int LEN_W       = 8,
  parameter int ADDR_STRIDE = 8,
  parameter int TAG_DEPTH   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                calib_done,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LEN_W-1:0]  req_len,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic [1:0]          wr_valid,
  output logic [1:0]          wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [1:0]          rd_valid,
  output logic                busy,
  output logic                err_orphan,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask
`ifdef DDR3_ARB_STATS_EN
  ,
  output logic [31:0]         stat_wr_bursts,
  output logic [31:0]         stat_rd_bursts
`endif
);
  state_t state, nxt;
  logic g, last_grant, win, fire_wr, fire_rd, fire, pop;
  logic tag_dout, tag_empty, tag_full;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] rem;
  assign win          = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign fire_wr      = ~reset & (state == WR) & app_rdy & app_wdf_rdy & wr_valid[g];
  assign fire_rd      = ~reset & (state == RD) & app_rdy & ~tag_full;
  assign fire         = fire_wr | fire_rd;
  assign pop          = app_rd_data_valid & ~tag_empty;
  assign app_en       = fire;
  assign app_cmd      = (state == RD) ? APP_CMD_READ : APP_CMD_WRITE;
  assign app_addr     = addr;
  assign app_wdf_wren = fire_wr;
  assign app_wdf_end  = fire_wr;
  assign app_wdf_data = fire_wr ? (g ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0]) : '0;
  assign app_wdf_mask = '0;
  assign wr_ready     = fire_wr ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign req_ready    = (state == GRANT) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign rd_valid     = pop ? (tag_dout ? 2'b10 : 2'b01) : 2'b00;
  assign rd_data      = app_rd_data;
  assign busy         = (state != IDLE) | ~tag_empty;
  ddr3_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk), .reset(reset), .push(fire_rd), .pop(pop), .din(g),
    .dout(tag_dout), .empty(tag_empty), .full(tag_full)
  );
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  // next state: grant only when calibrated, hold the grant until the last burst fires
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (calib_done && |req_valid) ? GRANT : IDLE;
      GRANT:   nxt = req_write[g] ? WR : RD;
      default: nxt = (fire && rem == '0) ? IDLE : state;
    endcase
  end
  // grant, address walk, burst countdown and sticky orphan flag
  always_ff @(posedge clk)
    if (reset) begin
      g          <= 1'b0;
      last_grant <= 1'b1;
      addr       <= '0;
      rem        <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (state == IDLE) g <= win;
      if (state == GRANT) begin
        last_grant <= g;
        addr       <= g ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        rem        <= g ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
      end else if (fire) begin
        addr <= addr + ADDR_W'(ADDR_STRIDE);
        rem  <= rem - LEN_W'(1);
      end
      err_orphan <= err_orphan | (app_rd_data_valid & tag_empty);
    end
`ifdef DDR3_ARB_STATS_EN
  // saturating fired-burst counters
  always_ff @(posedge clk)
    if (reset) begin
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
    end else begin
      if (fire_wr && ~&stat_wr_bursts) stat_wr_bursts <= stat_wr_bursts + 32'd1;
      if (fire_rd && ~&stat_rd_bursts) stat_rd_bursts <= stat_rd_bursts + 32'd1;
    end
`endif
endmodule
